// File: rtl/multi_voice_song_reader_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding and the
// layout of a song word {adv, note, dur}.
package multi_voice_song_reader_pkg;

    typedef enum logic [2:0] {
        ST_PAUSED   = 3'd0,
        ST_FETCH    = 3'd1,
        ST_ROM_WAIT = 3'd2,
        ST_DECODE   = 3'd3,
        ST_DISPATCH = 3'd4,
        ST_ADVANCE  = 3'd5,
        ST_NEXT     = 3'd6,
        ST_END      = 3'd7
    } state_t;

    // Duration sits in the low bits, note above it, advance flag on top.
    localparam int DUR_LSB = 0;

    function automatic int note_lsb(input int dur_w);
        return dur_w;
    endfunction

    function automatic int adv_bit(input int note_w, input int dur_w);
        return note_w + dur_w;
    endfunction

endpackage

// File: rtl/multi_voice_song_reader_beat_countdown.sv
// Beat-driven countdown used while an advance word holds the sequencer.
// A load always wins over a beat in the same cycle, so that beat is not counted.
module multi_voice_song_reader_beat_countdown
    import multi_voice_song_reader_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         beat,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (beat && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    // The beat that takes the count to zero releases the hold in the same cycle.
    assign done = (count_reg == '0) || (beat && (count_reg == W'(1)));

endmodule

// File: rtl/multi_voice_song_reader.sv
// Song sequencer: walks a song in an external ROM and hands each note to the
// lowest-index free voice, with advance holds, pause/resume and optional looping.
module multi_voice_song_reader
    import multi_voice_song_reader_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int SONG_SEL_W = 2,
    parameter int IDX_W      = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play,
    input  logic                         loop,
    input  logic [SONG_SEL_W-1:0]        song,
    input  logic                         beat,
    input  logic [NUM_VOICES-1:0]        voice_free,
    output logic [SONG_SEL_W+IDX_W-1:0]  rom_addr,
    input  logic [NOTE_W+DUR_W:0]        rom_data,
    output logic [NUM_VOICES*NOTE_W-1:0] note_out,
    output logic [NUM_VOICES*DUR_W-1:0]  dur_out,
    output logic [NUM_VOICES-1:0]        new_note,
    output logic                         song_done,
    output logic                         busy
);

    localparam int ADV_BIT  = adv_bit(NOTE_W, DUR_W);
    localparam int NOTE_LSB = note_lsb(DUR_W);

    state_t state_reg, state_next;

    logic [IDX_W-1:0]               idx_reg;
    logic [SONG_SEL_W-1:0]          song_q_reg;
    logic [SONG_SEL_W+IDX_W-1:0]    rom_addr_reg;
    logic [NOTE_W-1:0]              note_q_reg;
    logic [DUR_W-1:0]               dur_q_reg;
    logic [NUM_VOICES-1:0]          new_note_reg;
    logic                           song_done_reg;

    logic                           rom_adv;
    logic [NOTE_W-1:0]              rom_note;
    logic [DUR_W-1:0]               rom_dur;
    logic                           rom_is_end;

    logic [NUM_VOICES-1:0]          sel_onehot;
    logic                           any_free;

    logic                           take_song;
    logic                           addr_load;
    logic                           word_load;
    logic                           timer_load;
    logic                           timer_beat;
    logic                           timer_done;
    logic                           dispatch_fire;
    logic                           idx_step;
    logic                           end_fire;

    assign rom_adv    = rom_data[ADV_BIT];
    assign rom_note   = rom_data[NOTE_LSB +: NOTE_W];
    assign rom_dur    = rom_data[DUR_LSB +: DUR_W];
    assign rom_is_end = (rom_data == '0);

    // Lowest-index free voice wins.
    always_comb begin
        sel_onehot = '0;
        any_free   = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_free[v] && !any_free) begin
                sel_onehot[v] = 1'b1;
                any_free      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_PAUSED;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_PAUSED:   if (play) state_next = ST_FETCH;
            ST_FETCH:    state_next = ST_ROM_WAIT;
            ST_ROM_WAIT: state_next = ST_DECODE;
            ST_DECODE: begin
                if (rom_is_end) begin
                    state_next = ST_END;
                end else if (rom_adv) begin
                    state_next = ST_ADVANCE;
                end else begin
                    state_next = ST_DISPATCH;
                end
            end
            ST_DISPATCH: if (any_free) state_next = ST_NEXT;
            ST_ADVANCE:  if (timer_done) state_next = ST_NEXT;
            ST_NEXT:     state_next = (&idx_reg) ? ST_END : ST_FETCH;
            ST_END:      state_next = loop ? ST_FETCH : ST_PAUSED;
            default:     state_next = ST_PAUSED;
        endcase
        // Pause overrides everything except the end-of-song bookkeeping.
        if (!play && (state_reg != ST_END)) begin
            state_next = ST_PAUSED;
        end
    end

    always_comb begin
        take_song     = 1'b0;
        addr_load     = 1'b0;
        word_load     = 1'b0;
        timer_load    = 1'b0;
        timer_beat    = 1'b0;
        dispatch_fire = 1'b0;
        idx_step      = 1'b0;
        end_fire      = 1'b0;
        unique case (state_reg)
            ST_PAUSED:   take_song = play;
            ST_FETCH:    addr_load = 1'b1;
            ST_DECODE: begin
                word_load  = 1'b1;
                timer_load = rom_adv;
            end
            ST_DISPATCH: dispatch_fire = play && any_free;
            ST_ADVANCE:  timer_beat = play && beat;
            ST_NEXT:     idx_step = play;
            ST_END:      end_fire = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_reg       <= '0;
            song_q_reg    <= '0;
            rom_addr_reg  <= '0;
            note_q_reg    <= '0;
            dur_q_reg     <= '0;
            new_note_reg  <= '0;
            song_done_reg <= 1'b0;
        end else begin
            if (take_song) begin
                song_q_reg <= song;
                // A different song starts from its beginning; the same song resumes in place.
                if (song != song_q_reg) begin
                    idx_reg <= '0;
                end
            end else if (end_fire) begin
                idx_reg <= '0;
            end else if (idx_step) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end

            if (addr_load) begin
                rom_addr_reg <= {song_q_reg, idx_reg};
            end

            if (word_load) begin
                note_q_reg <= rom_note;
                dur_q_reg  <= rom_dur;
            end

            new_note_reg  <= dispatch_fire ? sel_onehot : '0;
            song_done_reg <= end_fire;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [NOTE_W-1:0] note_reg;
            logic [DUR_W-1:0]  dur_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    note_reg <= '0;
                    dur_reg  <= '0;
                end else if (dispatch_fire && sel_onehot[gi]) begin
                    note_reg <= note_q_reg;
                    dur_reg  <= dur_q_reg;
                end
            end

            assign note_out[gi*NOTE_W +: NOTE_W] = note_reg;
            assign dur_out[gi*DUR_W +: DUR_W]    = dur_reg;
        end
    endgenerate

    multi_voice_song_reader_beat_countdown #(
        .W(DUR_W)
    ) u_beat_countdown (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .value (rom_dur),
        .beat  (timer_beat),
        .done  (timer_done)
    );

    assign rom_addr  = rom_addr_reg;
    assign new_note  = new_note_reg;
    assign song_done = song_done_reg;
    assign busy      = (state_reg != ST_PAUSED);

endmodule

// File: tb/tb_multi_voice_song_reader.sv
// Directed bench for multi_voice_song_reader: a song-level scoreboard checks every
// strobe and per-voice output, and the scenarios pin exact cycle timings.
module tb_multi_voice_song_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        loop;
    logic [1:0]  song;
    logic        beat;
    logic [2:0]  voice_free;
    logic [6:0]  rom_addr;
    logic [12:0] rom_data;
    logic [17:0] note_out;
    logic [17:0] dur_out;
    logic [2:0]  new_note;
    logic        song_done;
    logic        busy;

    multi_voice_song_reader dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .loop       (loop),
        .song       (song),
        .beat       (beat),
        .voice_free (voice_free),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note_out   (note_out),
        .dur_out    (dur_out),
        .new_note   (new_note),
        .song_done  (song_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [12:0] rom_mem [0:127];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] vf_at_edge;
    logic       rst_at_edge;
    always @(posedge clk) begin
        vf_at_edge  <= voice_free;
        rst_at_edge <= reset;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Song-level model: expected notes in dispatch order and pending end-of-song pulses.
    logic [5:0] exp_note[$];
    logic [5:0] exp_dur[$];
    int         exp_done = 0;
    logic [5:0] shadow_note [3];
    logic [5:0] shadow_dur  [3];

    function automatic logic [12:0] mk(input logic adv, input logic [5:0] n, input logic [5:0] d);
        return {adv, n, d};
    endfunction

    task automatic model_song(input int s);
        logic [12:0] w;
        for (int i = 0; i < 32; i++) begin
            w = rom_mem[s*32 + i];
            if (w == 13'd0) break;
            if (!w[12]) begin
                exp_note.push_back(w[11:6]);
                exp_dur.push_back(w[5:0]);
            end
        end
        exp_done++;
    endtask

    function automatic int lowest_idx(input logic [2:0] f);
        for (int i = 0; i < 3; i++) if (f[i]) return i;
        return -1;
    endfunction

    logic       chk_en      = 1'b0;
    logic       expect_busy = 1'b0;
    int         strobe_cnt  = 0;
    int         done_cnt    = 0;
    int         last_strobe_cyc = 0;
    int         done_cyc    = 0;
    logic [6:0] prev_addr   = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_at_edge) begin
                exp_note.delete();
                exp_dur.delete();
                exp_done = 0;
                for (int v = 0; v < 3; v++) begin
                    shadow_note[v] = '0;
                    shadow_dur[v]  = '0;
                end
            end else begin
                if (new_note !== 3'b000) begin
                    int v;
                    v = lowest_idx(vf_at_edge);
                    check("strobe_voice", new_note, (v < 0) ? 3'b000 : (3'b001 << v));
                    check("strobe_expected", exp_note.size() > 0, 1'b1);
                    if (exp_note.size() > 0 && v >= 0) begin
                        shadow_note[v] = exp_note.pop_front();
                        shadow_dur[v]  = exp_dur.pop_front();
                    end
                    strobe_cnt++;
                    last_strobe_cyc = cyc;
                end
                if (song_done === 1'b1) begin
                    check("done_expected", exp_done > 0, 1'b1);
                    if (exp_done > 0) exp_done--;
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (expect_busy) check("busy_held", busy, 1'b1);
            end
            for (int v = 0; v < 3; v++) begin
                check("note_out", note_out[v*6 +: 6], shadow_note[v]);
                check("dur_out", dur_out[v*6 +: 6], shadow_dur[v]);
            end
            prev_addr = rom_addr;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [6:0] a, input int budget, output int c);
        int n = 0;
        while (rom_addr !== a && n < budget) begin
            tick();
            n++;
        end
        check("addr_reached", rom_addr, a);
        c = cyc;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("strobe_count", strobe_cnt, target);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("done_count", done_cnt, target);
    endtask

    task automatic beat_at(input int k);
        while (cyc < k) tick();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic tick_until(input int k);
        while (cyc < k) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, a, x, y;
        for (int i = 0; i < 128; i++) rom_mem[i] = '0;
        rom_mem[32] = mk(1'b0, 6'd10, 6'd8);
        rom_mem[33] = mk(1'b0, 6'd12, 6'd4);
        rom_mem[64] = mk(1'b1, 6'd0, 6'd3);
        rom_mem[65] = mk(1'b0, 6'd20, 6'd5);
        rom_mem[66] = mk(1'b1, 6'd0, 6'd0);
        rom_mem[67] = mk(1'b0, 6'd21, 6'd6);
        for (int i = 0; i < 32; i++) rom_mem[96 + i] = mk(1'b0, 6'(i + 1), 6'((i % 7) + 1));
        for (int v = 0; v < 3; v++) begin
            shadow_note[v] = '0;
            shadow_dur[v]  = '0;
        end

        reset = 1'b0; play = 1'b0; loop = 1'b0; song = 2'd0; beat = 1'b0; voice_free = 3'b111;
        repeat (3) tick();
        check("rst_rom_addr", rom_addr, 7'd0);
        check("rst_note_out", note_out, 18'd0);
        check("rst_dur_out", dur_out, 18'd0);
        check("rst_new_note", new_note, 3'd0);
        check("rst_song_done", song_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        chk_en = 1'b1;
        reset = 1'b1;
        tick();

        // Two plain notes on song 1, every voice free.
        model_song(1);
        song = 2'd1; play = 1'b1; c0 = cyc;
        wait_strobes(1, 20);
        check("t1_latency1", last_strobe_cyc - c0, 5);
        check("t1_note0", note_out[5:0], 6'd10);
        check("t1_dur0", dur_out[5:0], 6'd8);
        wait_strobes(2, 20);
        check("t1_latency2", last_strobe_cyc - c0, 10);
        check("t1_note0b", note_out[5:0], 6'd12);
        check("t1_dur0b", dur_out[5:0], 6'd4);
        wait_dones(1, 20);
        play = 1'b0;
        check("t1_done_cyc", done_cyc - c0, 15);
        check("t1_busy_fall", busy, 1'b0);
        check("t1_queue", exp_note.size(), 0);
        $display("t1 done: strobes=%0d dones=%0d", strobe_cnt, done_cnt);

        // All voices busy stalls the second note until voice 1 frees up.
        model_song(1);
        play = 1'b1; voice_free = 3'b111;
        wait_strobes(3, 20);
        voice_free = 3'b000;
        repeat (20) tick();
        check("t2_stalled", strobe_cnt, 3);
        check("t2_busy", busy, 1'b1);
        voice_free = 3'b010;
        wait_strobes(4, 5);
        check("t2_new_note", new_note, 3'b010);
        check("t2_note1", note_out[11:6], 6'd12);
        check("t2_dur1", dur_out[11:6], 6'd4);
        check("t2_note0_held", note_out[5:0], 6'd10);
        voice_free = 3'b111;
        wait_dones(2, 30);
        play = 1'b0;
        check("t2_queue", exp_note.size(), 0);
        $display("t2 done: strobes=%0d dones=%0d", strobe_cnt, done_cnt);

        // Advance hold of 3 beats (load-cycle beat ignored), then zero-length advance.
        model_song(2);
        song = 2'd2; play = 1'b1;
        wait_addr(7'd64, 20, a);
        beat_at(a + 1);
        beat_at(a + 11);
        beat_at(a + 21);
        beat_at(a + 31);
        wait_addr(7'd65, 20, x);
        check("t3_adv3_release", x - a, 34);
        wait_addr(7'd66, 20, x);
        check("t3_note_fetch", x - a, 39);
        check("t3_strobe_cyc", last_strobe_cyc - a, 37);
        wait_addr(7'd67, 20, y);
        check("t3_adv0_gap", y - x, 5);
        wait_dones(3, 30);
        play = 1'b0;
        check("t3_queue", exp_note.size(), 0);
        $display("t3 done: strobes=%0d dones=%0d", strobe_cnt, done_cnt);

        // Pause inside an advance after one beat; resume refetches and counts all 3 again.
        model_song(2);
        play = 1'b1;
        wait_addr(7'd64, 20, a);
        beat_at(a + 11);
        tick_until(a + 15);
        play = 1'b0;
        tick_until(a + 17);
        check("t4_paused", busy, 1'b0);
        tick_until(a + 20);
        play = 1'b1;
        beat_at(a + 30);
        beat_at(a + 40);
        beat_at(a + 50);
        wait_addr(7'd65, 20, x);
        check("t4_resume_release", x - a, 53);
        wait_dones(4, 40);
        play = 1'b0;
        check("t4_queue", exp_note.size(), 0);
        $display("t4 done: strobes=%0d dones=%0d", strobe_cnt, done_cnt);

        // Looping over a full 32-entry song: wrap, pulse, restart without pausing.
        model_song(3);
        model_song(3);
        loop = 1'b1; song = 2'd3; play = 1'b1;
        wait_addr(7'd127, 400, x);
        expect_busy = 1'b1;
        wait_dones(5, 20);
        check("t5_done_cyc", done_cyc - x, 5);
        wait_addr(7'd96, 10, y);
        check("t5_refetch_cyc", y - x, 6);
        c0 = strobe_cnt;
        wait_strobes(c0 + 3, 40);
        check("t5_second_pass_note", note_out[5:0], 6'd3);
        voice_free = 3'b000;
        repeat (8) tick();
        check("t5_stall_busy", busy, 1'b1);
        $display("t5 done: strobes=%0d dones=%0d", strobe_cnt, done_cnt);

        // Reset while stalled in dispatch clears everything at once.
        expect_busy = 1'b0;
        loop = 1'b0;
        reset = 1'b0;
        tick();
        check("t6_rom_addr", rom_addr, 7'd0);
        check("t6_note_out", note_out, 18'd0);
        check("t6_dur_out", dur_out, 18'd0);
        check("t6_new_note", new_note, 3'd0);
        check("t6_song_done", song_done, 1'b0);
        check("t6_busy", busy, 1'b0);
        reset = 1'b1; voice_free = 3'b111;
        model_song(3);
        c0 = cyc;
        wait_addr(7'd96, 10, x);
        check("t6_first_fetch", x - c0, 2);
        c0 = strobe_cnt;
        wait_strobes(c0 + 1, 20);
        check("t6_first_note", note_out[5:0], 6'd1);
        check("t6_first_dur", dur_out[5:0], 6'd1);
        $display("t6 done: strobes=%0d dones=%0d", strobe_cnt, done_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
